// File: rtl/instr_feeder_pkg.sv
// Shared constants and types for the instruction feeder: word and address
// widths, issue timing, the idle word and the two-state FSM encoding.
package instr_feeder_pkg;

    localparam int INSTR_WIDTH  = 20;
    localparam int PC_BITS      = 5;
    localparam int DEPTH        = 1 << PC_BITS;
    localparam int ISSUE_CYCLES = 3;
    localparam int HC_BITS      = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 20'h00000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_t;

    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [PC_BITS-1:0]     pc_t;
    typedef logic [PC_BITS:0]       len_t;
    typedef logic [HC_BITS-1:0]     hc_t;

    // Next address one bit wider than pc so that reaching DEPTH reads as
    // "past the end" instead of wrapping silently to zero.
    function automatic len_t pc_plus1(pc_t pc);
        return {1'b0, pc} + len_t'(1);
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Host-side bus of the instruction feeder: program-load port, run control
// and the registered instruction stream toward the CPU.
//
// Signalling: there is no valid/ready pair. prog_wen, start and halt are
// single-cycle strobes sampled on the rising edge (start only in IDLE,
// halt only in RUN, prog_wen only in IDLE). On the output side, issue is
// the valid qualifier: it is high for exactly the first cycle a new word
// sits on instruction; the consumer cannot stall the stream.
interface instr_feeder_if;
    import instr_feeder_pkg::*;

    logic       prog_wen;
    pc_t        prog_addr;
    instr_t     prog_data;
    len_t       prog_len;
    logic       loop;
    logic       start;
    logic       halt;

    instr_t     instruction;
    logic       issue;
    pc_t        pc;
    logic       busy;
    logic       done;
    fsm_state_t state;

    modport master (
        output prog_wen, prog_addr, prog_data, prog_len, loop, start, halt,
        input  instruction, issue, pc, busy, done, state
    );

    modport slave (
        input  prog_wen, prog_addr, prog_data, prog_len, loop, start, halt,
        output instruction, issue, pc, busy, done, state
    );

endinterface

// File: rtl/instr_feeder_prog_mem.sv
// Program memory: DEPTH x INSTR_WIDTH words, synchronous write, asynchronous
// read. Deliberately not reset so a loaded program survives a reset.
module instr_feeder_prog_mem
    import instr_feeder_pkg::*;
(
    input  logic   clk,
    input  logic   we_i,
    input  pc_t    waddr_i,
    input  instr_t wdata_i,
    input  pc_t    raddr_i,
    output instr_t rdata_o
);

    instr_t mem_q [DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: replays program words 0..len-1 onto a registered
// instruction output, holding each for ISSUE_CYCLES clocks, optionally
// looping, and driving NOP_WORD whenever it is not running.
module instr_feeder
    import instr_feeder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    instr_feeder_if.slave bus
);

    localparam hc_t HC_LAST = hc_t'(ISSUE_CYCLES - 1);

    fsm_state_t state_q;
    instr_t     instr_q;
    logic       issue_q;
    pc_t        pc_q;
    logic       busy_q;
    logic       done_q;
    hc_t        hc_q;
    len_t       len_q;
    logic       lp_q;

    len_t       nxt_d;
    pc_t        rd_addr_d;
    instr_t     rd_data;
    logic       mem_we_d;

    // Single read port: the next sequential word while a run continues,
    // otherwise address 0 (used both to start a run and to wrap a loop).
    always_comb begin
        nxt_d     = pc_plus1(pc_q);
        rd_addr_d = '0;
        if (state_q == S_RUN && nxt_d < len_q) begin
            rd_addr_d = nxt_d[PC_BITS-1:0];
        end
        mem_we_d  = bus.prog_wen && (state_q == S_IDLE) && !rst;
    end

    instr_feeder_prog_mem u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we_d),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data)
    );

    // Run-control FSM with every output registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= NOP_WORD;
            issue_q <= 1'b0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hc_q    <= '0;
            len_q   <= '0;
            lp_q    <= 1'b0;
        end else begin
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.prog_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            len_q   <= bus.prog_len;
                            lp_q    <= bus.loop;
                            pc_q    <= '0;
                            hc_q    <= '0;
                            instr_q <= rd_data;
                            issue_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.halt) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        instr_q <= NOP_WORD;
                        pc_q    <= '0;
                        hc_q    <= '0;
                    end else if (hc_q != HC_LAST) begin
                        hc_q <= hc_q + hc_t'(1);
                    end else if (nxt_d < len_q) begin
                        pc_q    <= nxt_d[PC_BITS-1:0];
                        hc_q    <= '0;
                        instr_q <= rd_data;
                        issue_q <= 1'b1;
                    end else if (lp_q) begin
                        pc_q    <= '0;
                        hc_q    <= '0;
                        instr_q <= rd_data;
                        issue_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        instr_q <= NOP_WORD;
                        pc_q    <= '0;
                        hc_q    <= '0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instruction = instr_q;
    assign bus.issue       = issue_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: directed scenarios plus randomized back-to-back
// runs. Each issued word is checked against a scoreboard queue filled when
// the run is launched, using a bench-side copy of program memory.
module tb_instr_feeder;
    import instr_feeder_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    instr_t          model_mem [DEPTH];
    logic [24:0]     exp_q [$];
    instr_t          last_word;

    instr_feeder_if bus ();

    instr_feeder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the edge, pop the
    // scoreboard on every issue and verify the held word otherwise.
    task automatic step();
        logic [24:0] exp;
        @(posedge clk);
        #1;
        if (bus.issue === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: issue with pc=%0d instr=%h but no word expected", bus.pc, bus.instruction);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.pc, bus.instruction} !== exp) begin
                    n_fail++;
                    $display("FAIL sb_word: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.pc, bus.instruction, exp[24:20], exp[19:0]);
                end
            end
            last_word = bus.instruction;
        end else if (bus.busy === 1'b1) begin
            n_tests++;
            if (bus.instruction !== last_word) begin
                n_fail++;
                $display("FAIL hold: instr=%h changed, expected held %h", bus.instruction, last_word);
            end
        end
    endtask

    task automatic prog_write(input pc_t addr, input instr_t data);
        bus.prog_wen  = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        step();
        bus.prog_wen  = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pc_t'(i), model_mem[i]});
        end
    endtask

    // Returns in the cycle right after the start edge.
    task automatic run_start(input len_t len, input logic lp);
        bus.prog_len = len;
        bus.loop     = lp;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.instruction !== NOP_WORD || bus.issue !== 1'b0 || bus.pc !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset: instr=%h issue=%b pc=%0d busy=%b done=%b state=%0d, required 00000/0/0/0/0/0",
                     bus.instruction, bus.issue, bus.pc, bus.busy, bus.done, bus.state);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_run();
        logic e_issue, e_busy, e_done;
        prog_write(5'd0, 20'h1A001);
        prog_write(5'd1, 20'h2B002);
        prog_write(5'd2, 20'h3C003);
        push_words(3);
        run_start(6'd3, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) step();
            e_issue = (k == 1 || k == 4 || k == 7);
            e_busy  = (k <= 9);
            e_done  = (k == 10);
            n_tests++;
            if (bus.issue !== e_issue || bus.busy !== e_busy || bus.done !== e_done) begin
                n_fail++;
                $display("FAIL single_run cycle %0d: issue=%b busy=%b done=%b, required %b/%b/%b",
                         k, bus.issue, bus.busy, bus.done, e_issue, e_busy, e_done);
            end
        end
        n_tests++;
        if (bus.instruction !== NOP_WORD || bus.pc !== '0) begin
            n_fail++;
            $display("FAIL single_run_end: instr=%h pc=%0d, required 00000/0", bus.instruction, bus.pc);
        end
        step();
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_run_pulse: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_loop();
        push_words(3);
        exp_q.push_back({5'd0, model_mem[0]});
        run_start(6'd3, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            n_tests++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.issue !== (k % 3 == 1)) begin
                n_fail++;
                $display("FAIL loop cycle %0d: busy=%b done=%b issue=%b, required 1/0/%b",
                         k, bus.busy, bus.done, bus.issue, (k % 3 == 1));
            end
        end
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.instruction !== NOP_WORD || bus.pc !== '0 ||
            bus.issue !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_halt: busy=%b instr=%h pc=%0d issue=%b done=%b, required 0/00000/0/0/0",
                     bus.busy, bus.instruction, bus.pc, bus.issue, bus.done);
        end
        step();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_after_halt: done=%b busy=%b, required 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_zero_len();
        run_start(6'd0, 1'b0);
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.instruction !== NOP_WORD) begin
            n_fail++;
            $display("FAIL zero_len: done=%b busy=%b instr=%h, required 1/0/00000",
                     bus.done, bus.busy, bus.instruction);
        end
        step();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.instruction !== NOP_WORD) begin
            n_fail++;
            $display("FAIL zero_len_after: done=%b busy=%b instr=%h, required 0/0/00000",
                     bus.done, bus.busy, bus.instruction);
        end
    endtask

    task automatic test_wen_in_run();
        push_words(3);
        run_start(6'd3, 1'b0);
        step();
        bus.prog_wen  = 1'b1;
        bus.prog_addr = 5'd1;
        bus.prog_data = 20'hFFFFF;
        step();
        bus.prog_wen  = 1'b0;
        wait_done(20);
        push_words(3);
        run_start(6'd3, 1'b0);
        step();
        step();
        step();
        n_tests++;
        if (bus.instruction !== 20'h2B002 || bus.pc !== 5'd1) begin
            n_fail++;
            $display("FAIL wen_in_run: instr=%h pc=%0d, required 2b002/1", bus.instruction, bus.pc);
        end
        wait_done(20);
    endtask

    task automatic test_rst_mid_run();
        push_words(2);
        run_start(6'd3, 1'b0);
        for (int k = 2; k <= 5; k++) step();
        rst = 1'b1;
        step();
        n_tests++;
        if (bus.instruction !== NOP_WORD || bus.pc !== '0 || bus.busy !== 1'b0 ||
            bus.issue !== 1'b0 || bus.state !== S_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_run: instr=%h pc=%0d busy=%b issue=%b state=%0d, required 00000/0/0/0/0",
                     bus.instruction, bus.pc, bus.busy, bus.issue, bus.state);
        end
        rst = 1'b0;
        push_words(1);
        run_start(6'd1, 1'b0);
        n_tests++;
        if (bus.instruction !== 20'h1A001) begin
            n_fail++;
            $display("FAIL rst_replay: instr=%h, required 1a001", bus.instruction);
        end
        wait_done(10);
    endtask

    task automatic test_start_halt_idle();
        bus.halt = 1'b1;
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.issue !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_idle: busy=%b done=%b issue=%b, required 0/0/0", bus.busy, bus.done, bus.issue);
        end
        push_words(1);
        run_start(6'd2, 1'b0);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.issue !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wins: busy=%b issue=%b, required 1/1", bus.busy, bus.issue);
        end
        step();
        bus.halt = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.instruction !== NOP_WORD || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_run: busy=%b instr=%h done=%b, required 0/00000/0",
                     bus.busy, bus.instruction, bus.done);
        end
    endtask

    task automatic test_full_len();
        for (int i = 0; i < DEPTH; i++) begin
            prog_write(pc_t'(i), instr_t'(i));
        end
        push_words(DEPTH);
        run_start(len_t'(DEPTH), 1'b0);
        for (int k = 1; k <= DEPTH * ISSUE_CYCLES; k++) begin
            if (k > 1) step();
            n_tests++;
            if (bus.pc !== pc_t'((k - 1) / ISSUE_CYCLES) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL full_len cycle %0d: pc=%0d busy=%b done=%b, required %0d/1/0",
                         k, bus.pc, bus.busy, bus.done, (k - 1) / ISSUE_CYCLES);
            end
        end
        step();
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== '0 || bus.instruction !== NOP_WORD) begin
            n_fail++;
            $display("FAIL full_len_end: done=%b busy=%b pc=%0d instr=%h, required 1/0/0/00000",
                     bus.done, bus.busy, bus.pc, bus.instruction);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        int busy_cycles;
        for (int i = 0; i < 8; i++) begin
            prog_write(pc_t'(i), instr_t'($urandom_range(0, 20'hFFFFF)));
        end
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 8);
            push_words(len);
            run_start(len_t'(len), 1'b0);
            busy_cycles = 0;
            while (bus.busy === 1'b1 && busy_cycles < 100) begin
                busy_cycles++;
                step();
            end
            n_tests++;
            if (busy_cycles !== len * ISSUE_CYCLES || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back round %0d: busy %0d cycles done=%b, required %0d cycles then done=1",
                         r, busy_cycles, bus.done, len * ISSUE_CYCLES);
            end
        end
        step();
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        last_word      = NOP_WORD;
        rst            = 1'b1;
        bus.prog_wen   = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.prog_len   = '0;
        bus.loop       = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        test_reset();
        test_single_run();
        test_loop();
        test_zero_len();
        test_wen_in_run();
        test_rst_mid_run();
        test_start_halt_idle();
        test_full_len();
        test_back_to_back();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d words never issued, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction source for `simple_cpu`, and the producer end of its 20-bit `instruction` input. It holds a small program memory that a host or testbench loads word by word. On `start`, it replays addresses 0 .. `prog_len`-1 onto `instruction`, holding each word for `ISSUE_CYCLES` clocks so the multi-cycle CU can consume it. It drives `NOP_WORD` whenever it is not running.

## Interface
- `INSTR_WIDTH`, 20: instruction word width; matches the CPU input.
- `PC_BITS`, 5: program memory has 2^`PC_BITS` words.
- `ISSUE_CYCLES`, 3: clocks each instruction is held; must be ≥1.
- `NOP_WORD`, 20'h00000: value driven when idle or halted.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `prog_wen`, in, 1: program-memory write strobe.
- `prog_addr`, in, `PC_BITS`: write address.
- `prog_data`, in, `INSTR_WIDTH`: write data.
- `prog_len`, in, `PC_BITS`+1: number of words to run, 0..2^`PC_BITS`; sampled at `start`.
- `loop`, in, 1: 1 means wrap to address 0 after the last word; sampled at `start`.
- `start`, in, 1: begin a run; honoured only in IDLE.
- `halt`, in, 1: abort a run.
- `instruction`, out, `INSTR_WIDTH`: registered word to the CPU.
- `issue`, out, 1: high in the first cycle a new word is on `instruction`.
- `pc`, out, `PC_BITS`: address of the word currently driven.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse when a non-looping run completes.

## Operation
- States are IDLE and RUN. The registers are `pc`, a hold counter `hc` (0..`ISSUE_CYCLES`-1), the latched length `len`, and the latched `lp`.
- Reset values:
  - state IDLE, `instruction` = `NOP_WORD`
  - `issue` = 0, `pc` = 0, `busy` = 0, `done` = 0, `hc` = 0
  - Program memory is not cleared by reset.
- Writes:
  - A write occurs when `prog_wen`=1 in IDLE: mem[`prog_addr`] ← `prog_data` at the clock edge.
  - `prog_wen` in RUN is ignored and memory is unchanged.
- IDLE with `start`=1 and `prog_len`=0: stay in IDLE and pulse `done`.
- IDLE with `start`=1 and `prog_len`>0:
  - Next state is RUN; `len` ← `prog_len`, `lp` ← `loop`.
  - `pc` ← 0, `hc` ← 0, `instruction` ← mem[0], `issue` ← 1.
- RUN with `hc` < `ISSUE_CYCLES`-1: `hc` increments; `instruction` and `pc` are held; `issue` = 0.
- RUN with `hc` = `ISSUE_CYCLES`-1: let `nxt` = `pc`+1, computed in `PC_BITS`+1 bits.
  - If `nxt` < `len`: `pc` ← `nxt`, `hc` ← 0, `instruction` ← mem[`nxt`], `issue` ← 1.
  - Else if `lp`=1: `pc` ← 0 and load mem[0] as above. Wrap-around is silent, with no `done`.
  - Else: go to IDLE, `instruction` ← `NOP_WORD`, `pc` ← 0, `done` ← 1.
- `halt`=1 in RUN has priority over advancing.
  - Next cycle: IDLE, `NOP_WORD`, `pc` = 0, `issue` = 0.
  - No `done` is pulsed.
- Signals with no effect:
  - `halt` in IDLE is ignored.
  - `start` in RUN is ignored.
  - If `start` and `halt` are both 1 in IDLE, `start` wins.
- `rst` overrides everything, including a simultaneous `start` or `prog_wen`. A reset mid-run returns to IDLE next cycle with `NOP_WORD`.
- When `prog_len` = 2^`PC_BITS`, the run covers every address; `nxt` reaching 2^`PC_BITS` means the end of the run, not a wrap to 0 (unless `lp`).

## Timing
- The cycle after the `start` edge presents mem[0] with `issue`=1.
- Each word stays stable for exactly `ISSUE_CYCLES` clocks.
- A non-looping run of N words has `busy` high for N·`ISSUE_CYCLES` cycles. In the following cycle, `done`=1, `busy`=0 and `NOP_WORD` is driven.
- Memory read is combinational from the array into the registered `instruction`. A word written in IDLE is visible to a `start` in the next cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- The shared header `cpu_defs.vh` holds:
  - `INSTR_WIDTH` default (20)
  - NOP encoding
  - state encodings IDLE=1'b0, RUN=1'b1
- The `simple_cpu` and bench both include `cpu_defs.vh`.
- One sub-module, `prog_mem`: 2^`PC_BITS` × `INSTR_WIDTH`, synchronous write, asynchronous read, no reset.
- The top-level bench instantiates `instr_feeder` feeding `simple_cpu.instruction`, sharing `clk`/`rst`.

## Test plan
- Load mem[0..2] = 20'h1A001, 20'h2B002, 20'h3C003; `prog_len`=3, `loop`=0, `start` → three words, each held 3 cycles, with `issue` on cycles 1, 4 and 7. `done`=1 at cycle 10, after which `NOP_WORD` is driven.
- Same program with `loop`=1 → after 20'h3C003, `pc`=0 and 20'h1A001 reappear with no `done`; `halt` at cycle 12 → IDLE and `NOP_WORD` at cycle 13.
- `prog_len`=0 with `start` → single `done` pulse, `busy` never rises, `instruction` stays 20'h00000.
- `prog_wen` during RUN at address 1 with 20'hFFFFF → mem[1] unchanged; the word read back in the next run is 20'h2B002.
- `rst` asserted mid-run (cycle 5) → next cycle `instruction`=20'h00000, `pc`=0, `busy`=0. Memory is retained, so a new `start` replays 20'h1A001.
- `prog_len`=32 with all addresses loaded with their own index → `pc` runs 0..31 without wrapping; `done` follows the 32nd word.
